// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the push-button front end.
// Pad indices used when wiring buttons to the game logic.
package button_conditioner_pkg;

    localparam int BTN_IDX_LEFT  = 0;
    localparam int BTN_IDX_RIGHT = 1;
    localparam int BTN_IDX_A     = 2;
    localparam int BTN_IDX_B     = 3;
    localparam int N_BTNS        = 4;

    // The state encoding doubles as the debounced level.
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between pads, conditioner and game logic.
// Raw pads in; debounced level and edge pulses out.
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTNS = N_BTNS
);

    logic [NUM_BTNS-1:0] BTN_RAW;
    logic [NUM_BTNS-1:0] BTN_LEVEL;
    logic [NUM_BTNS-1:0] BTN_PRESS;
    logic [NUM_BTNS-1:0] BTN_REL;

    modport master (
        output BTN_RAW,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_REL
    );

    modport slave (
        input  BTN_RAW,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_REL
    );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button: 2-FF synchroniser, counter debounce, level and pulses.
// A change is accepted only after DEBOUNCE_CYCLES uninterrupted cycles.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    btn_state_e       state;
    btn_state_e       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_nx;
    logic             rel_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= raw ^ ACTIVE_LOW;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
            press <= press_nx;
            rel   <= rel_nx;
        end
    end

    // Counter clears whenever s2 agrees with the stable state,
    // so any bounce restarts the count.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    if (cnt == TERM) begin
                        state_nx = HELD;
                        press_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!s2) begin
                    if (cnt == TERM) begin
                        state_nx = IDLE;
                        rel_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign level = (state == HELD);

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: one independent debounce channel per pad.
// Channels share only clock and reset.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTNS        = N_BTNS,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    button_conditioner_if.slave  btn
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk   (CLK),
            .rst_n (RESET_N),
            .raw   (btn.BTN_RAW[i]),
            .level (btn.BTN_LEVEL[i]),
            .press (btn.BTN_PRESS[i]),
            .rel   (btn.BTN_REL[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random bench for button_conditioner (DEBOUNCE_CYCLES=8).
// Reference: a change is accepted once the 2-cycle-delayed input has disagreed for D cycles.
module tb_button_conditioner;

    localparam int D = 8;

    logic CLK = 1'b0;
    logic RESET_N = 1'b1;

    button_conditioner_if #(.NUM_BTNS(4)) bif ();

    button_conditioner #(
        .NUM_BTNS        (4),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .btn     (bif.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [3:0] hist[$];
    logic [3:0] m_level = '0;
    logic [3:0] m_press = '0;
    logic [3:0] m_rel   = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
    endtask

    // One rising edge: update the reference, then compare all outputs.
    task automatic step();
        logic [3:0] flip;
        bit all_diff;
        @(posedge CLK);
        flip = '0;
        if (!RESET_N) begin
            model_clear();
        end else begin
            for (int c = 0; c < 4; c++) begin
                all_diff = (hist.size() >= D + 1);
                for (int k = 0; k < D; k++)
                    if (all_diff && hist[hist.size()-2-k][c] == m_level[c])
                        all_diff = 1'b0;
                flip[c] = all_diff;
            end
            hist.push_back(bif.BTN_RAW);
            m_press = flip & ~m_level;
            m_rel   = flip & m_level;
            m_level = m_level ^ flip;
        end
        #1;
        chk("level", 32'(bif.BTN_LEVEL), 32'(m_level));
        chk("press", 32'(bif.BTN_PRESS), 32'(m_press));
        chk("rel",   32'(bif.BTN_REL),   32'(m_rel));
        assert ((bif.BTN_PRESS & bif.BTN_REL) == 4'h0) else begin
            errors++;
            $error("FAIL press_and_rel observed=%0h expected=0",
                   bif.BTN_PRESS & bif.BTN_REL);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges until the chosen pulse appears on ch; -1 if budget expires.
    task automatic wait_pulse(input int ch, input bit is_rel, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if ((is_rel ? bif.BTN_REL[ch] : bif.BTN_PRESS[ch]) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic assert_reset();
        RESET_N = 1'b0;
        model_clear();
        #1;
        chk("async_rst_level", 32'(bif.BTN_LEVEL), 32'h0);
        chk("async_rst_press", 32'(bif.BTN_PRESS), 32'h0);
        chk("async_rst_rel",   32'(bif.BTN_REL),   32'h0);
    endtask

    initial begin
        int n;
        int hold[4];
        logic [3:0] r;

        // 1: held through reset
        bif.BTN_RAW = 4'hF;
        #1;
        assert_reset();
        steps(3);
        RESET_N = 1'b1;
        wait_pulse(0, 1'b0, n);
        chk("t1_press_latency", 32'(n), 32'd10);
        chk("t1_press_all", 32'(bif.BTN_PRESS), 32'hF);
        chk("t1_level_all", 32'(bif.BTN_LEVEL), 32'hF);
        bif.BTN_RAW = 4'h0;
        wait_pulse(0, 1'b1, n);
        chk("t1_rel_latency", 32'(n), 32'd10);
        steps(3);

        // 2: clean press and release on ch0
        bif.BTN_RAW = 4'h1;
        wait_pulse(0, 1'b0, n);
        chk("t2_press_latency", 32'(n), 32'd10);
        step();
        chk("t2_press_one_cycle", 32'(bif.BTN_PRESS[0]), 32'h0);
        bif.BTN_RAW = 4'h0;
        wait_pulse(0, 1'b1, n);
        chk("t2_rel_latency", 32'(n), 32'd10);
        steps(3);

        // 3: bounce on ch1, then hold
        for (int b = 0; b < 4; b++) begin
            bif.BTN_RAW = (b % 2 == 0) ? 4'h2 : 4'h0;
            steps(3);
        end
        bif.BTN_RAW = 4'h2;
        wait_pulse(1, 1'b0, n);
        chk("t3_bounce_press_latency", 32'(n), 32'd10);
        bif.BTN_RAW = 4'h0;
        steps(14);

        // 4: 7-cycle glitch on ch2
        bif.BTN_RAW = 4'h4;
        steps(7);
        bif.BTN_RAW = 4'h0;
        steps(12);
        chk("t4_glitch_level", 32'(bif.BTN_LEVEL[2]), 32'h0);

        // 5: independence
        bif.BTN_RAW = 4'h9;
        steps(3);
        bif.BTN_RAW = 4'hB;
        wait_pulse(0, 1'b0, n);
        chk("t5_ch0_latency", 32'(n), 32'd7);
        chk("t5_ch3_same_cycle", 32'(bif.BTN_PRESS[3]), 32'h1);
        chk("t5_ch1_not_yet", 32'(bif.BTN_PRESS[1]), 32'h0);
        wait_pulse(1, 1'b0, n);
        chk("t5_ch1_offset", 32'(n), 32'd3);
        bif.BTN_RAW = 4'h0;
        steps(14);

        // 6: reset at count 5
        bif.BTN_RAW = 4'h1;
        steps(7);
        assert_reset();
        steps(2);
        RESET_N = 1'b1;
        wait_pulse(0, 1'b0, n);
        chk("t6_press_after_reset", 32'(n), 32'd10);
        bif.BTN_RAW = 4'h0;
        steps(14);

        // random hold lengths straddling the debounce window
        for (int c = 0; c < 4; c++) hold[c] = 0;
        r = 4'h0;
        repeat (800) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    r[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 14);
                end else begin
                    hold[c]--;
                end
            end
            bif.BTN_RAW = r;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
